// File: rtl/pcie_led_status.sv
// Front-panel status LEDs for a PCIe endpoint: heartbeat, debounced link state
// with a link-lost blink, stretched AXI activity, and a saturating link-drop counter.
module pcie_led_status #(
    parameter int CLK_HZ       = 62500000,
    parameter int HEARTBEAT_HZ = 1,
    parameter int DEBOUNCE     = 1024,
    parameter int STRETCH      = 6250000,
    parameter int BLINK        = 3125000,
    parameter int LOST_HOLD    = 62500000
) (
    input  logic       user_clk,
    input  logic       user_reset,
    input  logic       user_lnk_up,
    input  logic       axi_rx_act,
    input  logic       axi_tx_act,
    output logic [2:0] led,
    output logic [7:0] lnk_drop_cnt,
    output logic [1:0] dbg_state
);

    localparam int HB_HALF = CLK_HZ / (2 * HEARTBEAT_HZ);

    localparam int HW = (HB_HALF   > 1) ? $clog2(HB_HALF)   : 1;
    localparam int QW = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
    localparam int LW = (LOST_HOLD > 1) ? $clog2(LOST_HOLD) : 1;
    localparam int BW = (BLINK     > 1) ? $clog2(BLINK)     : 1;
    localparam int SW = $clog2(STRETCH + 1);

    localparam logic [HW-1:0] HB_LAST   = HW'(HB_HALF - 1);
    localparam logic [QW-1:0] Q_LAST    = QW'(DEBOUNCE - 1);
    localparam logic [LW-1:0] L_LAST    = LW'(LOST_HOLD - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(BLINK - 1);
    localparam logic [SW-1:0] S_LOAD    = SW'(STRETCH);
    localparam logic [7:0]    DROP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_QUAL = 2'd1,
        ST_UP   = 2'd2,
        ST_LOST = 2'd3
    } state_t;

    state_t          state;
    logic [HW-1:0]   hcnt;
    logic [QW-1:0]   qcnt;
    logic [LW-1:0]   lcnt;
    logic [BW-1:0]   bcnt;
    logic [SW-1:0]   scnt;
    logic            hb_led;
    logic            lnk_led;
    logic            blink_ph;
    logic            act;

    assign act       = axi_rx_act | axi_tx_act;
    assign led       = {(scnt != '0), lnk_led, hb_led};
    assign dbg_state = state;

    // Free-running heartbeat, independent of link state.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            hcnt   <= '0;
            hb_led <= 1'b0;
        end else if (hcnt == HB_LAST) begin
            hcnt   <= '0;
            hb_led <= ~hb_led;
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Link FSM with its counters, the link LED, the activity stretcher and
    // the drop counter; the link LED follows the state one cycle later.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state        <= ST_DOWN;
            qcnt         <= '0;
            lcnt         <= '0;
            bcnt         <= '0;
            blink_ph     <= 1'b0;
            lnk_led      <= 1'b0;
            scnt         <= '0;
            lnk_drop_cnt <= '0;
        end else begin
            lnk_led <= (state == ST_UP) || ((state == ST_LOST) && blink_ph);

            if (scnt != '0) begin
                scnt <= scnt - SW'(1);
            end

            case (state)
                ST_DOWN: begin
                    if (user_lnk_up) begin
                        state <= ST_QUAL;
                        qcnt  <= '0;
                    end
                end

                ST_QUAL: begin
                    if (!user_lnk_up) begin
                        state <= ST_DOWN;
                    end else if (qcnt == Q_LAST) begin
                        state <= ST_UP;
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end

                ST_UP: begin
                    if (!user_lnk_up) begin
                        // Leaving UP kills any pending activity even if a pulse arrives now.
                        state    <= ST_LOST;
                        lcnt     <= '0;
                        bcnt     <= '0;
                        blink_ph <= 1'b0;
                        scnt     <= '0;
                        if (lnk_drop_cnt != DROP_MAX) begin
                            lnk_drop_cnt <= lnk_drop_cnt + 8'd1;
                        end
                    end else if (act) begin
                        scnt <= S_LOAD;
                    end
                end

                ST_LOST: begin
                    if (user_lnk_up) begin
                        state <= ST_QUAL;
                        qcnt  <= '0;
                    end else begin
                        if (lcnt == L_LAST) begin
                            state <= ST_DOWN;
                        end else begin
                            lcnt <= lcnt + LW'(1);
                        end
                        if (bcnt == B_LAST) begin
                            bcnt     <= '0;
                            blink_ph <= ~blink_ph;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end

                default: begin
                    state <= ST_DOWN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_led_status.sv
// Directed plus randomized bench for pcie_led_status, checked every cycle
// against an arithmetic reference model of the LED and drop-counter behaviour.
module tb_pcie_led_status;

    localparam int CLK_HZ       = 16;
    localparam int HEARTBEAT_HZ = 1;
    localparam int DEBOUNCE     = 4;
    localparam int STRETCH      = 5;
    localparam int BLINK        = 2;
    localparam int LOST_HOLD    = 10;
    localparam int HB_HALF      = CLK_HZ / (2 * HEARTBEAT_HZ);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lnk = 1'b0;
    logic       rx  = 1'b0;
    logic       tx  = 1'b0;
    logic [2:0] led;
    logic [7:0] drops;
    logic [1:0] dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: link mode, cycles spent in the mode, edges since reset,
    // edge index of the last counted activity event.
    typedef enum {MD_DOWN, MD_QUAL, MD_UP, MD_LOST} mode_t;
    mode_t m_mode;
    int    m_e;
    int    m_cnt;
    int    m_drops;
    int    m_last_evt;
    logic  m_led1;

    always #5 clk = ~clk;

    pcie_led_status #(
        .CLK_HZ      (CLK_HZ),
        .HEARTBEAT_HZ(HEARTBEAT_HZ),
        .DEBOUNCE    (DEBOUNCE),
        .STRETCH     (STRETCH),
        .BLINK       (BLINK),
        .LOST_HOLD   (LOST_HOLD)
    ) dut (
        .user_clk    (clk),
        .user_reset  (rst),
        .user_lnk_up (lnk),
        .axi_rx_act  (rx),
        .axi_tx_act  (tx),
        .led         (led),
        .lnk_drop_cnt(drops),
        .dbg_state   (dbg)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = MD_DOWN;
        m_e        = 0;
        m_cnt      = 0;
        m_drops    = 0;
        m_last_evt = -1000;
        m_led1     = 1'b0;
    endtask

    task automatic model_edge();
        logic lk;
        logic ev;
        lk = lnk;
        ev = rx | tx;
        m_e++;
        m_led1 = (m_mode == MD_UP) || (m_mode == MD_LOST && ((m_cnt / BLINK) % 2 == 1));
        case (m_mode)
            MD_DOWN: if (lk) begin m_mode = MD_QUAL; m_cnt = 0; end
            MD_QUAL: begin
                if (!lk) m_mode = MD_DOWN;
                else if (m_cnt + 1 == DEBOUNCE) m_mode = MD_UP;
                else m_cnt++;
            end
            MD_UP: begin
                if (!lk) begin
                    m_mode     = MD_LOST;
                    m_cnt      = 0;
                    m_drops    = (m_drops < 255) ? m_drops + 1 : 255;
                    m_last_evt = -1000;
                end else if (ev) begin
                    m_last_evt = m_e;
                end
            end
            default: begin
                if (lk) begin m_mode = MD_QUAL; m_cnt = 0; end
                else if (m_cnt + 1 == LOST_HOLD) m_mode = MD_DOWN;
                else m_cnt++;
            end
        endcase
    endtask

    task automatic check_all();
        chk("hb_led",   {7'b0, led[0]}, 8'((m_e / HB_HALF) % 2));
        chk("lnk_led",  {7'b0, led[1]}, {7'b0, m_led1});
        chk("act_led",  {7'b0, led[2]}, {7'b0, ((m_e - m_last_evt) < STRETCH)});
        chk("drop_cnt", drops, 8'(m_drops));
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic drive(input logic l, input logic r, input logic t);
        lnk = l;
        rx  = r;
        tx  = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_led",  {5'b0, led}, 8'h00);
        chk("reset_drop", drops, 8'h00);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int hold;
        model_reset();

        // Heartbeat with link down; an rx pulse in DOWN must not light led[2].
        do_reset();
        tick(5);
        drive(1'b0, 1'b1, 1'b0);
        tick(1);
        drive(1'b0, 1'b0, 1'b0);
        tick(28);

        // Debounce: 3 high, 1 low glitch, then continuously high.
        drive(1'b1, 1'b0, 1'b0);
        tick(3);
        drive(1'b0, 1'b0, 1'b0);
        tick(1);
        drive(1'b1, 1'b0, 1'b0);
        tick(8);
        chk("link_up_led", {7'b0, led[1]}, 8'h01);

        // Activity: rx at N, rx+tx at N+3.
        drive(1'b1, 1'b1, 1'b0);
        tick(1);
        drive(1'b1, 1'b0, 1'b0);
        tick(2);
        drive(1'b1, 1'b1, 1'b1);
        tick(1);
        drive(1'b1, 1'b0, 1'b0);
        tick(8);

        // Loss, relink during LOST, then a drop held long enough to reach DOWN.
        drive(1'b0, 1'b0, 1'b0);
        tick(6);
        drive(1'b1, 1'b0, 1'b0);
        tick(7);
        drive(1'b0, 1'b0, 1'b0);
        tick(12);
        chk("drop_two", drops, 8'd2);

        // Randomized link and activity traffic.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                lnk  = 1'($urandom_range(0, 1));
                hold = lnk ? $urandom_range(1, 25) : $urandom_range(1, 14);
            end
            hold--;
            rx = ($urandom_range(0, 3) == 0);
            tx = ($urandom_range(0, 4) == 0);
            tick(1);
        end

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick(6);
            drive(1'b0, 1'b0, 1'b0);
            tick(1);
        end
        chk("drop_sat", drops, 8'd255);

        // Asynchronous reset while UP with the activity LED lit.
        drive(1'b1, 1'b0, 1'b0);
        tick(6);
        drive(1'b1, 1'b1, 1'b0);
        tick(1);
        drive(1'b1, 1'b0, 1'b0);
        tick(1);
        chk("act_before_rst", {7'b0, led[2]}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("async_led",  {5'b0, led}, 8'h00);
        chk("async_drop", drops, 8'h00);
        do_reset();
        tick(34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
